// File: rtl/spi_mult_frame_ctrl.sv
// Frame-level controller above a 16-bit SPI engine: receives operands A and B,
// multiplies them with a shift-add datapath and returns the product as two frames.
module spi_mult_frame_ctrl #(
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    rx_valid,
  input  logic [DATA_WIDTH-1:0]   rx_data,
  input  logic                    tx_done,
  output logic                    spi_rx_start,
  output logic                    spi_tx_start,
  output logic [DATA_WIDTH-1:0]   tx_data,
  output logic [2*DATA_WIDTH-1:0] product,
  output logic                    product_valid,
  output logic                    busy,
  output logic                    timeout_err
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] BIT_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [15:0]   TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam bit            TMO_EN   = (TIMEOUT_CYCLES != 0);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT_A  = 3'd1,
    S_WAIT_B  = 3'd2,
    S_MULT    = 3'd3,
    S_SEND_HI = 3'd4,
    S_SEND_LO = 3'd5
  } state_t;

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] op_a_q, op_a_d;
  logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
  logic [PW-1:0]         mcand_q, mcand_d;
  logic [PW-1:0]         acc_q, acc_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [15:0]           tmo_cnt_q, tmo_cnt_d;

  logic                  spi_rx_start_q, spi_rx_start_d;
  logic                  spi_tx_start_q, spi_tx_start_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic [PW-1:0]         product_q, product_d;
  logic                  product_valid_q, product_valid_d;
  logic                  busy_q, busy_d;
  logic                  timeout_err_q, timeout_err_d;

  logic [PW-1:0] acc_sum_s;
  logic          mult_last_s;
  logic          timed_s;
  logic          strobe_s;
  logic          tmo_hit_s;

  assign acc_sum_s   = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign mult_last_s = (state_q == S_MULT) && (bit_cnt_q == BIT_LAST);
  // A strobe arriving on the terminal-count cycle takes priority over the abort.
  assign tmo_hit_s   = TMO_EN && timed_s && !strobe_s && (tmo_cnt_q == TMO_LAST);

  always_comb begin
    timed_s  = 1'b0;
    strobe_s = 1'b0;
    case (state_q)
      S_WAIT_B: begin
        timed_s  = 1'b1;
        strobe_s = rx_valid;
      end
      S_SEND_HI, S_SEND_LO: begin
        timed_s  = 1'b1;
        strobe_s = tx_done;
      end
      default: begin
        timed_s  = 1'b0;
        strobe_s = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_WAIT_A;
        else        state_d = S_IDLE;
      end
      S_WAIT_A: begin
        if (rx_valid)     state_d = S_WAIT_B;
        else if (!enable) state_d = S_IDLE;
        else              state_d = S_WAIT_A;
      end
      S_WAIT_B: begin
        if (rx_valid)       state_d = S_MULT;
        else if (tmo_hit_s) state_d = S_IDLE;
        else                state_d = S_WAIT_B;
      end
      S_MULT: begin
        if (mult_last_s) state_d = S_SEND_HI;
        else             state_d = S_MULT;
      end
      S_SEND_HI: begin
        if (tx_done)        state_d = S_SEND_LO;
        else if (tmo_hit_s) state_d = S_IDLE;
        else                state_d = S_SEND_HI;
      end
      S_SEND_LO: begin
        if (tx_done || tmo_hit_s) state_d = S_IDLE;
        else                      state_d = S_SEND_LO;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    op_a_d    = op_a_q;
    mplier_d  = mplier_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    bit_cnt_d = bit_cnt_q;
    // Counter restarts whenever a timed state is entered or left.
    if (timed_s && (state_d == state_q)) tmo_cnt_d = tmo_cnt_q + 16'd1;
    else                                 tmo_cnt_d = 16'd0;
    case (state_q)
      S_WAIT_A: begin
        if (rx_valid) op_a_d = rx_data;
        else          op_a_d = op_a_q;
      end
      S_WAIT_B: begin
        if (rx_valid) begin
          acc_d     = '0;
          mcand_d   = PW'(op_a_q);
          mplier_d  = rx_data;
          bit_cnt_d = '0;
        end else begin
          acc_d     = acc_q;
        end
      end
      S_MULT: begin
        acc_d     = acc_sum_s;
        mcand_d   = mcand_q << 1;
        mplier_d  = mplier_q >> 1;
        bit_cnt_d = bit_cnt_q + CW'(1);
      end
      default: begin
        acc_d = acc_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_a_q    <= '0;
      mplier_q  <= '0;
      mcand_q   <= '0;
      acc_q     <= '0;
      bit_cnt_q <= '0;
      tmo_cnt_q <= 16'd0;
    end else begin
      op_a_q    <= op_a_d;
      mplier_q  <= mplier_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      bit_cnt_q <= bit_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  always_comb begin
    spi_rx_start_d  = (state_d == S_WAIT_A) || (state_d == S_WAIT_B);
    spi_tx_start_d  = (state_d == S_SEND_HI) || (state_d == S_SEND_LO);
    busy_d          = (state_d != S_IDLE);
    timeout_err_d   = tmo_hit_s;
    product_valid_d = mult_last_s;
    if (mult_last_s) product_d = acc_sum_s;
    else             product_d = product_q;
    if (mult_last_s)                           tx_data_d = acc_sum_s[PW-1:DATA_WIDTH];
    else if ((state_q == S_SEND_HI) && tx_done) tx_data_d = product_q[DATA_WIDTH-1:0];
    else                                       tx_data_d = tx_data_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      spi_rx_start_q  <= 1'b0;
      spi_tx_start_q  <= 1'b0;
      tx_data_q       <= '0;
      product_q       <= '0;
      product_valid_q <= 1'b0;
      busy_q          <= 1'b0;
      timeout_err_q   <= 1'b0;
    end else begin
      spi_rx_start_q  <= spi_rx_start_d;
      spi_tx_start_q  <= spi_tx_start_d;
      tx_data_q       <= tx_data_d;
      product_q       <= product_d;
      product_valid_q <= product_valid_d;
      busy_q          <= busy_d;
      timeout_err_q   <= timeout_err_d;
    end
  end

  assign spi_rx_start  = spi_rx_start_q;
  assign spi_tx_start  = spi_tx_start_q;
  assign tx_data       = tx_data_q;
  assign product       = product_q;
  assign product_valid = product_valid_q;
  assign busy          = busy_q;
  assign timeout_err   = timeout_err_q;

endmodule
